// File: rtl/bht_ctrl.sv
// Branch history table controller: 256 x 2-bit saturating counters held in a dual-port SRAM.
// Port 0 serves fetch lookups; port 1 handles initialisation and update read-modify-write.
module bht_ctrl #(
  parameter logic [1:0] INIT_CTR = 2'b01,
  parameter int         IDX_LSB  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pred_req,
  input  logic [31:0] pred_pc,
  output logic        pred_ready,
  output logic        pred_valid,
  output logic        pred_taken,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  output logic        upd_ready,
  output logic        bht_csb0,
  output logic        bht_web0,
  output logic [7:0]  bht_addr0,
  output logic [1:0]  bht_din0,
  input  logic [1:0]  bht_dout0,
  output logic        bht_csb1,
  output logic        bht_web1,
  output logic [7:0]  bht_addr1,
  output logic [1:0]  bht_din1,
  input  logic [1:0]  bht_dout1
);
  typedef enum logic [1:0] {INIT, IDLE, UPD_WR} state_t;

  state_t     state, state_nxt;
  logic [7:0] init_idx;
  logic [7:0] upd_idx_q;
  logic       upd_taken_q;
  logic       byp_q, byp_bit_q;
  logic       pred_fire, upd_fire, byp_hit;
  logic [1:0] upd_new;
  logic [7:0] pred_idx, upd_idx;
  logic       unused_bits;

  assign pred_idx    = pred_pc[IDX_LSB +: 8];
  assign upd_idx     = upd_pc[IDX_LSB +: 8];
  assign unused_bits = ^{pred_pc, upd_pc, bht_dout0[0]};

  always_comb begin
    if (upd_taken_q) upd_new = (bht_dout1 == 2'b11) ? 2'b11 : bht_dout1 + 2'd1;
    else             upd_new = (bht_dout1 == 2'b00) ? 2'b00 : bht_dout1 - 2'd1;
  end

  // Port drives are gated by rst so a reset cycle never issues a write.
  always_comb begin
    state_nxt  = state;
    pred_ready = 1'b0;
    upd_ready  = 1'b0;
    upd_fire   = 1'b0;
    pred_fire  = 1'b0;
    byp_hit    = 1'b0;
    bht_csb0   = 1'b1;
    bht_web0   = 1'b1;
    bht_addr0  = 8'd0;
    bht_din0   = 2'b00;
    bht_csb1   = 1'b1;
    bht_web1   = 1'b1;
    bht_addr1  = 8'd0;
    bht_din1   = 2'b00;
    if (!rst) begin
      case (state)
        INIT: begin
          bht_csb1  = 1'b0;
          bht_web1  = 1'b0;
          bht_addr1 = init_idx;
          bht_din1  = INIT_CTR;
          if (init_idx == 8'hff) state_nxt = IDLE;
        end
        IDLE: begin
          pred_ready = 1'b1;
          upd_ready  = 1'b1;
          if (upd_valid) begin
            upd_fire  = 1'b1;
            bht_csb1  = 1'b0;
            bht_addr1 = upd_idx;
            state_nxt = UPD_WR;
          end
        end
        UPD_WR: begin
          pred_ready = 1'b1;
          bht_csb1   = 1'b0;
          bht_web1   = 1'b0;
          bht_addr1  = upd_idx_q;
          bht_din1   = upd_new;
          state_nxt  = IDLE;
        end
        default: state_nxt = INIT;
      endcase
      pred_fire = pred_req & pred_ready;
      if (pred_fire) begin
        bht_csb0  = 1'b0;
        bht_addr0 = pred_idx;
      end
      // Port 0 returns the pre-write value on a same-cycle collision.
      byp_hit = pred_fire && (state == UPD_WR) && (pred_idx == upd_idx_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= INIT;
      init_idx    <= 8'd0;
      upd_idx_q   <= 8'd0;
      upd_taken_q <= 1'b0;
      pred_valid  <= 1'b0;
      byp_q       <= 1'b0;
      byp_bit_q   <= 1'b0;
    end else begin
      state      <= state_nxt;
      if (state == INIT) init_idx <= init_idx + 8'd1;
      if (upd_fire) begin
        upd_idx_q   <= upd_idx;
        upd_taken_q <= upd_taken;
      end
      pred_valid <= pred_fire;
      byp_q      <= byp_hit;
      byp_bit_q  <= upd_new[1];
    end
  end

  assign pred_taken = pred_valid & (byp_q ? byp_bit_q : bht_dout0[1]);

endmodule

// File: tb/tb_bht_ctrl.sv
// Self-checking bench for bht_ctrl: SRAM model, directed scenarios and a randomized run
// checked against a counter-array reference model.
module tb_bht_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pred_req = 1'b0;
  logic [31:0] pred_pc = 32'd0;
  logic        pred_ready, pred_valid, pred_taken;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = 32'd0;
  logic        upd_taken = 1'b0;
  logic        upd_ready;
  logic        bht_csb0, bht_web0, bht_csb1, bht_web1;
  logic [7:0]  bht_addr0, bht_addr1;
  logic [1:0]  bht_din0, bht_din1;
  logic [1:0]  bht_dout0 = 2'b00, bht_dout1 = 2'b00;

  int total = 0;
  int bad = 0;
  logic [1:0] ref_bht [256];
  logic [1:0] mem [256];

  bht_ctrl dut (
    .clk(clk), .rst(rst),
    .pred_req(pred_req), .pred_pc(pred_pc), .pred_ready(pred_ready),
    .pred_valid(pred_valid), .pred_taken(pred_taken),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_ready(upd_ready),
    .bht_csb0(bht_csb0), .bht_web0(bht_web0), .bht_addr0(bht_addr0),
    .bht_din0(bht_din0), .bht_dout0(bht_dout0),
    .bht_csb1(bht_csb1), .bht_web1(bht_web1), .bht_addr1(bht_addr1),
    .bht_din1(bht_din1), .bht_dout1(bht_dout1)
  );

  always #5 clk = ~clk;

  // Dual-port SRAM with one-cycle read latency.
  always @(posedge clk) begin
    if (!bht_csb0 && bht_web0) bht_dout0 <= mem[bht_addr0];
    if (!bht_csb1) begin
      if (!bht_web1) mem[bht_addr1] <= bht_din1;
      else           bht_dout1 <= mem[bht_addr1];
    end
  end

  function automatic logic [1:0] sat(input logic [1:0] c, input logic t);
    int v;
    v = t ? int'(c) + 1 : int'(c) - 1;
    if (v > 3) v = 3;
    if (v < 0) v = 0;
    return 2'(v);
  endfunction

  task automatic tick(); @(posedge clk); #1; endtask
  task automatic settle(); #1; endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    settle();
    total++;
    if ({pred_ready, upd_ready, pred_valid, pred_taken, bht_csb0, bht_web0, bht_csb1, bht_web1} !== 8'b0000_1111) begin
      bad++;
      $display("FAIL reset_outputs got=%b want=00001111",
               {pred_ready, upd_ready, pred_valid, pred_taken, bht_csb0, bht_web0, bht_csb1, bht_web1});
    end
  endtask

  // Expects rst just released in the current cycle (cycle 1 of init).
  task automatic check_init(input string nm);
    for (int i = 0; i < 256; i++) begin
      settle();
      total++;
      if (bht_csb1 !== 1'b0 || bht_web1 !== 1'b0 || bht_addr1 !== 8'(i) || bht_din1 !== 2'b01 ||
          pred_ready !== 1'b0 || upd_ready !== 1'b0 || bht_csb0 !== 1'b1) begin
        bad++;
        $display("FAIL %s_write%0d got csb1=%b web1=%b addr1=%0d din1=%b prdy=%b urdy=%b csb0=%b want 0 0 %0d 01 0 0 1",
                 nm, i, bht_csb1, bht_web1, bht_addr1, bht_din1, pred_ready, upd_ready, bht_csb0, i);
      end
      tick();
    end
    settle();
    total++;
    if (pred_ready !== 1'b1 || upd_ready !== 1'b1 || bht_csb1 !== 1'b1) begin
      bad++;
      $display("FAIL %s_ready257 got prdy=%b urdy=%b csb1=%b want 1 1 1", nm, pred_ready, upd_ready, bht_csb1);
    end
    for (int i = 0; i < 256; i++) ref_bht[i] = 2'b01;
  endtask

  task automatic test_init();
    rst = 1'b0;
    check_init("init");
  endtask

  task automatic do_lookup(input logic [31:0] pc, input logic exp, input string nm);
    pred_req = 1'b1; pred_pc = pc;
    settle();
    total++;
    if (pred_ready !== 1'b1 || bht_csb0 !== 1'b0 || bht_web0 !== 1'b1 || bht_addr0 !== pc[9:2]) begin
      bad++;
      $display("FAIL %s_issue got rdy=%b csb0=%b web0=%b addr0=%h want 1 0 1 %h",
               nm, pred_ready, bht_csb0, bht_web0, bht_addr0, pc[9:2]);
    end
    tick();
    pred_req = 1'b0;
    settle();
    total++;
    if (pred_valid !== 1'b1 || pred_taken !== exp) begin
      bad++;
      $display("FAIL %s_result got valid=%b taken=%b want 1 %b", nm, pred_valid, pred_taken, exp);
    end
    tick();
    total++;
    if (pred_valid !== 1'b0) begin
      bad++;
      $display("FAIL %s_valid_pulse got=%b want=0", nm, pred_valid);
    end
  endtask

  task automatic do_update(input logic [31:0] pc, input logic t, input logic [1:0] exp, input string nm);
    upd_valid = 1'b1; upd_pc = pc; upd_taken = t;
    settle();
    total++;
    if (upd_ready !== 1'b1 || bht_csb1 !== 1'b0 || bht_web1 !== 1'b1 || bht_addr1 !== pc[9:2]) begin
      bad++;
      $display("FAIL %s_read got urdy=%b csb1=%b web1=%b addr1=%h want 1 0 1 %h",
               nm, upd_ready, bht_csb1, bht_web1, bht_addr1, pc[9:2]);
    end
    tick();
    upd_valid = 1'b0;
    settle();
    total++;
    if (upd_ready !== 1'b0 || pred_ready !== 1'b1 || bht_csb1 !== 1'b0 || bht_web1 !== 1'b0 ||
        bht_addr1 !== pc[9:2] || bht_din1 !== exp) begin
      bad++;
      $display("FAIL %s_write got urdy=%b prdy=%b csb1=%b web1=%b addr1=%h din1=%b want 0 1 0 0 %h %b",
               nm, upd_ready, pred_ready, bht_csb1, bht_web1, bht_addr1, bht_din1, pc[9:2], exp);
    end
    ref_bht[pc[9:2]] = exp;
    tick();
  endtask

  task automatic test_lookup();
    do_lookup(32'h0000_0010, 1'b0, "lookup_init");
  endtask

  task automatic test_update();
    do_update(32'h0000_0010, 1'b1, 2'b10, "upd_t1");
    do_update(32'h0000_0010, 1'b1, 2'b11, "upd_t2");
    do_lookup(32'h0000_0010, 1'b1, "lookup_after_upd");
  endtask

  task automatic test_saturation();
    do_update(32'h0000_0010, 1'b1, 2'b11, "sat_high");
    do_update(32'h0000_0020, 1'b0, 2'b00, "dec_to_00");
    do_update(32'h0000_0020, 1'b0, 2'b00, "sat_low");
    do_lookup(32'h0000_0020, 1'b0, "lookup_sat_low");
  endtask

  task automatic test_bypass();
    // pc 0x14 -> index 5, currently 01; taken update writes 10.
    upd_valid = 1'b1; upd_pc = 32'h0000_0014; upd_taken = 1'b1;
    tick();
    upd_valid = 1'b0;
    pred_req = 1'b1; pred_pc = 32'h0000_0014;
    settle();
    total++;
    if (bht_csb0 !== 1'b0 || bht_web1 !== 1'b0 || bht_din1 !== 2'b10) begin
      bad++;
      $display("FAIL bypass_collide got csb0=%b web1=%b din1=%b want 0 0 10", bht_csb0, bht_web1, bht_din1);
    end
    tick();
    pred_req = 1'b0;
    settle();
    total++;
    if (pred_valid !== 1'b1 || pred_taken !== 1'b1) begin
      bad++;
      $display("FAIL bypass_result got valid=%b taken=%b (sram=%b) want 1 1", pred_valid, pred_taken, bht_dout0);
    end
    ref_bht[5] = 2'b10;
    tick();
  endtask

  task automatic test_random();
    logic       busy = 1'b0, lk_pend = 1'b0, lk_exp = 1'b0;
    logic [7:0] pend_idx = 8'd0;
    logic       pend_t = 1'b0;
    logic [7:0] idx;
    for (int c = 0; c < 600; c++) begin
      // Update accepted last cycle becomes visible to lookups from this cycle on.
      if (busy) ref_bht[pend_idx] = sat(ref_bht[pend_idx], pend_t);
      pred_req  = ($urandom_range(0, 9) < 6);
      idx       = 8'($urandom_range(0, 7));
      pred_pc   = ($urandom & 32'hFFFF_FC00) | (32'(idx) << 2) | ($urandom & 32'h3);
      upd_valid = ($urandom_range(0, 1) == 1);
      idx       = 8'($urandom_range(0, 7));
      upd_pc    = ($urandom & 32'hFFFF_FC00) | (32'(idx) << 2) | ($urandom & 32'h3);
      upd_taken = ($urandom_range(0, 2) != 0) ^ c[8];
      settle();
      total++;
      if (pred_ready !== 1'b1 || upd_ready !== !busy || (busy && (bht_din1 !== ref_bht[pend_idx] || bht_web1 !== 1'b0))) begin
        bad++;
        $display("FAIL rand_ctl c=%0d got prdy=%b urdy=%b din1=%b want 1 %b %b",
                 c, pred_ready, upd_ready, bht_din1, !busy, ref_bht[pend_idx]);
      end
      lk_pend = pred_req;
      lk_exp  = ref_bht[pred_pc[9:2]][1];
      busy    = upd_valid && !busy;
      if (busy) begin pend_idx = upd_pc[9:2]; pend_t = upd_taken; end
      tick();
      total++;
      if (pred_valid !== lk_pend || (lk_pend && pred_taken !== lk_exp)) begin
        bad++;
        $display("FAIL rand_pred c=%0d got valid=%b taken=%b want %b %b", c, pred_valid, pred_taken, lk_pend, lk_exp);
      end
    end
    if (busy) ref_bht[pend_idx] = sat(ref_bht[pend_idx], pend_t);
    pred_req = 1'b0; upd_valid = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) do_lookup(32'(i) << 2, ref_bht[i][1], "rand_final");
  endtask

  task automatic test_reset_mid();
    upd_valid = 1'b1; upd_pc = 32'h0000_0018; upd_taken = 1'b1;
    tick();
    upd_valid = 1'b0;
    rst = 1'b1;
    settle();
    total++;
    if (bht_csb1 !== 1'b1 || bht_web1 !== 1'b1 || pred_ready !== 1'b0 || upd_ready !== 1'b0) begin
      bad++;
      $display("FAIL rst_in_updwr got csb1=%b web1=%b prdy=%b urdy=%b want 1 1 0 0",
               bht_csb1, bht_web1, pred_ready, upd_ready);
    end
    tick();
    rst = 1'b0;
    repeat (100) tick();
    settle();
    total++;
    if (bht_addr1 !== 8'd100 || bht_csb1 !== 1'b0) begin
      bad++;
      $display("FAIL init_reach100 got addr1=%0d csb1=%b want 100 0", bht_addr1, bht_csb1);
    end
    rst = 1'b1;
    settle();
    total++;
    if (bht_csb1 !== 1'b1 || bht_web1 !== 1'b1) begin
      bad++;
      $display("FAIL rst_in_init got csb1=%b web1=%b want 1 1", bht_csb1, bht_web1);
    end
    tick();
    rst = 1'b0;
    check_init("reinit");
    do_lookup(32'h0000_0010, 1'b0, "lookup_reinit");
  endtask

  initial begin
    test_reset();
    test_init();
    test_lookup();
    test_update();
    test_saturation();
    test_bypass();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end
endmodule
